// File: rtl/fact_pkg.sv
// Shared definitions for the factorial engine: controller state encoding,
// operand limit and down-counter width.
package fact_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        MUL   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } fact_state_t;

    localparam int FACT_N_MAX = 12;
    localparam int FACT_CNT_W = 4;

    // Cycle (counted from the go edge) in which done pulses for a legal n.
    function automatic int fact_done_cycle(input int n);
        int m;
        m = (n < 1) ? 1 : n;
        return 2 * m + 1;
    endfunction

endpackage

// File: rtl/fact_wdog.sv
// Saturating busy-cycle counter; expired stays high once LIMIT is reached
// until clr returns the count to zero.
module fact_wdog #(
    parameter int LIMIT = 31,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic expired
);

    localparam logic [W-1:0] LIMIT_C = W'(LIMIT);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (count != LIMIT_C) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT_C);

endmodule

// File: rtl/fact_ctrl_unit.sv
// Factorial engine controller: sequences load / check / multiply-down on the
// datapath. Optional busy watchdog enabled by defining FACT_CU_WDOG_EN.
module fact_ctrl_unit
    import fact_pkg::*;
#(
    parameter int WDOG_LIMIT = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        compared,
    input  logic        error,
    output logic        sel1,
    output logic        sel2,
    output logic        Load_cnt,
    output logic        Load_reg,
    output logic        EN,
    output logic        done,
    output logic        busy,
    output logic        err,
    output fact_state_t dbg_state
);

    // Handshake: go is accepted only on an edge where the unit is in IDLE;
    // exactly one done pulse follows each accepted go (success or error),
    // and go seen in any other state is dropped.

    fact_state_t state;
    fact_state_t next_state;
    logic        result_valid;
    logic        err_q;
    logic        go_accept;
    logic        wdog_expired;

    if (WDOG_LIMIT <= 2 * FACT_N_MAX + 1) begin : g_limit_check
        $error("WDOG_LIMIT must exceed the longest legal run");
    end

`ifdef FACT_CU_WDOG_EN
    logic wdog_clr;

    assign wdog_clr = (state == IDLE);

    fact_wdog #(
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wdog_clr),
        .expired (wdog_expired)
    );
`else
    assign wdog_expired = 1'b0;
`endif

    assign go_accept = (state == IDLE) && go;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (go) next_state = error ? ERR : LOAD;
            LOAD:    next_state = CHECK;
            CHECK:   next_state = compared ? MUL : DONE;
            MUL:     next_state = CHECK;
            DONE:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // A stuck loop is forced out; DONE/ERR already head back to IDLE.
        if (wdog_expired && (state inside {LOAD, CHECK, MUL})) begin
            next_state = ERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == ERR) begin
                err_q <= 1'b1;
            end else if (go_accept) begin
                err_q <= 1'b0;
            end
            if (state == DONE) begin
                result_valid <= 1'b1;
            end else if (go_accept) begin
                result_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        sel1     = 1'b0;
        sel2     = 1'b0;
        Load_cnt = 1'b0;
        Load_reg = 1'b0;
        EN       = 1'b0;
        done     = 1'b0;
        busy     = (state != IDLE);
        err      = err_q;
        case (state)
            IDLE: sel2 = result_valid;
            LOAD: begin
                Load_cnt = 1'b1;
                Load_reg = 1'b1;
            end
            MUL: begin
                sel1     = 1'b1;
                Load_reg = 1'b1;
                EN       = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                sel2 = 1'b1;
            end
            ERR:     done = 1'b1;
            default: ;
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_fact_ctrl_unit.sv
// Bench for fact_ctrl_unit with a behavioural datapath attached and a
// run-level reference model checked every cycle.
module tb_fact_ctrl_unit;
    import fact_pkg::*;

    localparam int WDOG = 31;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        compared;
    logic        error;
    logic        sel1, sel2, Load_cnt, Load_reg, EN, done, busy, err;
    fact_state_t dbg_state;

    logic [3:0]  n;
    logic        force_cmp;
    logic [3:0]  dp_cnt;
    logic [31:0] dp_reg;
    logic [31:0] product;
    bit          check_en;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fact_ctrl_unit #(.WDOG_LIMIT(WDOG)) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .compared  (compared),
        .error     (error),
        .sel1      (sel1),
        .sel2      (sel2),
        .Load_cnt  (Load_cnt),
        .Load_reg  (Load_reg),
        .EN        (EN),
        .done      (done),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // Datapath stand-in: down-counter, product register, status decodes.
    always @(posedge clk) begin
        if (rst) begin
            dp_cnt <= '0;
            dp_reg <= '0;
        end else begin
            if (Load_cnt) dp_cnt <= n;
            else if (EN) dp_cnt <= dp_cnt - 4'd1;
            if (Load_reg) dp_reg <= sel1 ? dp_reg * {28'd0, dp_cnt} : 32'd1;
        end
    end

    assign compared = force_cmp | (dp_cnt > 4'd1);
    assign error    = (n > 4'(FACT_N_MAX));
    assign product  = sel2 ? dp_reg : 32'd0;

    function automatic logic [31:0] fact(input int v);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 2; i <= v; i++) p = p * 32'(i);
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks runs by cycle index since the accepted go.
    bit          m_active, m_errpath, m_valid, m_err;
    int          m_k, m_end;
    logic [31:0] m_prod;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0;
            m_valid  = 0;
            m_err    = 0;
            m_prod   = 0;
        end else if (m_active) begin
            if (m_k == m_end) begin
                m_active = 0;
                m_valid  = !m_errpath;
                m_err    = m_errpath;
            end else begin
                m_k++;
            end
        end else if (go) begin
            m_active  = 1;
            m_k       = 1;
            m_errpath = (int'(n) > FACT_N_MAX);
            m_end     = m_errpath ? 1 : 2 * ((n == 0) ? 1 : int'(n)) + 1;
            m_valid   = 0;
            m_err     = 0;
            m_prod    = m_errpath ? 32'd0 : fact(int'(n));
        end
    end

    always @(negedge clk) begin
        logic e_done, e_err, e_sel2, e_load, e_mul;
        logic [7:0] e_vec;
        if (check_en) begin
            e_done = m_active && (m_k == m_end);
            e_err  = m_active ? m_errpath : m_err;
            e_sel2 = m_active ? (e_done && !m_errpath) : m_valid;
            e_load = m_active && !m_errpath && (m_k == 1);
            e_mul  = m_active && !m_errpath && (m_k >= 2) && (m_k < m_end) && ((m_k % 2) == 1);
            e_vec  = {e_mul, e_sel2, e_load, e_load | e_mul, e_mul, e_done, m_active, e_err};
            check("cycle_outputs", {24'd0, sel1, sel2, Load_cnt, Load_reg, EN, done, busy, err},
                  {24'd0, e_vec});
            check("cycle_product", product, e_sel2 ? m_prod : 32'd0);
        end
    end

    // Called just after a negedge; returns at the IDLE cycle after done.
    task automatic run(input logic [3:0] nv, input int exp_cyc, input logic [31:0] exp_prod,
                       input logic exp_err, input string tag);
        int cyc;
        bit seen;
        n    = nv;
        go   = 1'b1;
        @(negedge clk);
        go   = 1'b0;
        cyc  = 1;
        seen = 0;
        while (cyc <= 60) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_cycle"}, cyc, exp_cyc);
        check({tag, "_product"}, product, exp_prod);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cnt, d1, d2, cyc;
        bit seen;
        rst = 1'b1; go = 1'b0; n = '0; force_cmp = 1'b0; check_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {24'd0, sel1, sel2, Load_cnt, Load_reg, EN, done, busy, err}, 32'd0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        run(4'd5, 11, 32'd120, 1'b0, "n5");
        check("n5_sel2_idle", 32'(sel2), 32'd1);
        check("n5_product_idle", product, 32'd120);
        run(4'd0, 3, 32'd1, 1'b0, "n0");
        run(4'd1, 3, 32'd1, 1'b0, "n1");
        run(4'd13, 1, 32'd0, 1'b1, "n13");
        check("n13_err_sticky", 32'(err), 32'd1);
        check("n13_sel2_idle", 32'(sel2), 32'd0);
        run(4'd4, 9, 32'd24, 1'b0, "n4");
        run(4'd12, 25, 32'd479001600, 1'b0, "n12");

        // Second n=12 run aborted by reset.
        n = 4'd12; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", {24'd0, sel1, sel2, Load_cnt, Load_reg, EN, done, busy, err}, 32'd0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("abort_no_done", cnt, 0);

        // go held high across DONE restarts on the following IDLE cycle.
        n = 4'd2; go = 1'b1; d1 = 0; d2 = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (done && d1 == 0) d1 = c;
            else if (done) d2 = c;
        end
        go = 1'b0;
        check("held_go_first_done", d1, 5);
        check("held_go_second_done", d2, 11);
        repeat (2) @(negedge clk);

        // go pulsed while busy is ignored.
        n = 4'd3; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (2) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cnt = 0;
        repeat (16) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("busy_go_done_count", cnt, 1);
        check("busy_go_product", product, 32'd6);

        // compared stuck high.
        check_en = 1'b0;
        force_cmp = 1'b1;
        n = 4'd5; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cyc = 1; seen = 0;
`ifdef FACT_CU_WDOG_EN
        while (cyc <= 60) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check("wdog_done_seen", 32'(seen), 32'd1);
        check("wdog_err", 32'(err), 32'd1);
        check("wdog_cycle_window", 32'((cyc >= WDOG + 1) && (cyc <= WDOG + 2)), 32'd1);
`else
        cnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("stuck_no_done", cnt, 0);
        check("stuck_busy", 32'(busy), 32'd1);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        force_cmp = 1'b0;
        check_en = 1'b1;
        @(negedge clk);
        run(4'd3, 7, 32'd6, 1'b0, "post_reset_n3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
